// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bundle: redirect requests, instruction-memory handshake and decode hand-off.
// master = fetch sequencer, slave = surrounding core / memory / decode.
interface fetch_sequencer_if #(
    parameter int unsigned ADDRESS_BITS = 16
) ();
    logic                    branch_valid;
    logic [ADDRESS_BITS-1:0] branch_target;
    logic                    jump_valid;
    logic [ADDRESS_BITS-1:0] jump_target;
    logic                    trap_valid;
    logic [ADDRESS_BITS-1:0] trap_vector;

    logic                    imem_req_valid;
    logic [ADDRESS_BITS-1:0] imem_req_addr;
    logic                    imem_req_ready;
    logic                    imem_resp_valid;
    logic [31:0]             imem_resp_data;

    logic                    inst_valid;
    logic [31:0]             inst;
    logic [ADDRESS_BITS-1:0] inst_pc;
    logic                    inst_ready;

    modport master (
        input  branch_valid, branch_target, jump_valid, jump_target, trap_valid, trap_vector,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        output branch_valid, branch_target, jump_valid, jump_target, trap_valid, trap_vector,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: owns the fetch PC, arbitrates redirects, keeps one request
// outstanding and hands fetched instructions to decode.
module fetch_sequencer #(
    parameter int unsigned              ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0]  RESET_PC     = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fetch_sequencer_if.master io_fs
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e                  r_state;
    logic [ADDRESS_BITS-1:0] r_pc;
    logic                    r_kill;
    logic                    r_req_valid;
    logic                    r_inst_valid;
    logic [31:0]             r_inst;
    logic [ADDRESS_BITS-1:0] r_inst_pc;

    logic                    w_redirect;
    logic [ADDRESS_BITS-1:0] w_target_raw;
    logic [ADDRESS_BITS-1:0] w_target;
    logic [ADDRESS_BITS-1:0] w_pc_inc;

    always_comb begin
        w_redirect = io_fs.trap_valid | io_fs.jump_valid | io_fs.branch_valid;
        if (io_fs.trap_valid) begin
            w_target_raw = io_fs.trap_vector;
        end else if (io_fs.jump_valid) begin
            w_target_raw = io_fs.jump_target;
        end else begin
            w_target_raw = io_fs.branch_target;
        end
        w_target = {w_target_raw[ADDRESS_BITS-1:2], 2'b00};
        w_pc_inc = r_pc + ADDRESS_BITS'(4);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state     <= StReq;
                    r_req_valid <= 1'b1;
                    if (w_redirect) r_pc <= w_target;
                end
                StReq: begin
                    if (w_redirect) r_pc <= w_target;
                    if (io_fs.imem_req_ready) begin
                        // Accepted together with a redirect: the reply belongs to the old path.
                        r_kill      <= w_redirect;
                        r_req_valid <= 1'b0;
                        r_state     <= StWait;
                    end
                end
                StWait: begin
                    if (io_fs.imem_resp_valid) begin
                        r_kill <= 1'b0;
                        if (w_redirect) begin
                            r_pc        <= w_target;
                            r_req_valid <= 1'b1;
                            r_state     <= StReq;
                        end else if (r_kill) begin
                            r_req_valid <= 1'b1;
                            r_state     <= StReq;
                        end else begin
                            r_inst       <= io_fs.imem_resp_data;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= w_pc_inc;
                            r_state      <= StHold;
                        end
                    end else if (w_redirect) begin
                        r_pc   <= w_target;
                        r_kill <= 1'b1;
                    end
                end
                StHold: begin
                    if (w_redirect || io_fs.inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_state      <= StReq;
                        if (w_redirect) r_pc <= w_target;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_fs.imem_req_valid = r_req_valid;
    assign io_fs.imem_req_addr  = r_pc;
    assign io_fs.inst_valid     = r_inst_valid;
    assign io_fs.inst           = r_inst;
    assign io_fs.inst_pc        = r_inst_pc;
endmodule
